processador_tiro: RTL

// Downstream consumer of the fleet records written by the placement validator. On each shot request it scans
// the target player's 11-entry fleet memory for coordinate (x,y). It reports water/hit/repeat/sunk/game-over
// and writes the updated record back on a hit. Sits between the turn controller and the per-player fleet RAMs.

---
 rtl/batalha_pkg.sv | 44 ++++
 rtl/processador_tiro_comparador_registro.sv | 38 +++
 rtl/processador_tiro.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship fleet records: ship types, record
// field layout and the FSM state encoding of the shot processor.
package batalha_pkg;

    localparam int NUM_ENTRADAS = 11;
    localparam int TAM_TAB      = 10;

    localparam logic [2:0] PORTA_AVIOES = 3'd0;
    localparam logic [2:0] ENCOURACADO  = 3'd1;
    localparam logic [2:0] HIDROAVIAO   = 3'd2;
    localparam logic [2:0] CRUZADOR     = 3'd3;
    localparam logic [2:0] SUBMARINO    = 3'd4;

    // Slot k: x at [X_MSB_BASE+SLOT_PASSO*k -: 4], y at [Y_MSB_BASE+SLOT_PASSO*k -: 4]
    localparam int LARG_REG     = 64;
    localparam int NUM_SLOTS    = 5;
    localparam int SLOT_PASSO   = 8;
    localparam int X_MSB_BASE   = 6;
    localparam int Y_MSB_BASE   = 10;
    localparam int CONT_MSB     = 46;
    localparam int CONT_LSB     = 43;
    localparam int MASCARA_BASE = 47;
    localparam int LARG_UTIL    = MASCARA_BASE + NUM_SLOTS;

    typedef enum logic [2:0] {
        OCIOSO,
        LE,
        CMP,
        GRAVA,
        FIM
    } estado_t;

    function automatic logic [2:0] tamanho_tipo(input logic [2:0] tipo);
        case (tipo)
            PORTA_AVIOES: return 3'd5;
            ENCOURACADO:  return 3'd4;
            HIDROAVIAO:   return 3'd3;
            CRUZADOR:     return 3'd2;
            SUBMARINO:    return 3'd1;
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/processador_tiro_comparador_registro.sv
// Combinational match of one fleet record against a shot coordinate.
// Only the slots active for the record's ship type take part; lowest slot wins.
module comparador_registro
    import batalha_pkg::*;
(
    input  logic [LARG_UTIL-1:0] registro,
    input  logic [3:0]           x,
    input  logic [3:0]           y,
    output logic                 vazio,
    output logic                 casou,
    output logic [2:0]           slot,
    output logic                 ja_atingido
);

    logic [3:0]           contagem;
    logic [NUM_SLOTS-1:0] mascara;
    logic [2:0]           ativos;

    always_comb begin
        contagem    = registro[CONT_MSB:CONT_LSB];
        mascara     = registro[MASCARA_BASE +: NUM_SLOTS];
        ativos      = tamanho_tipo(registro[2:0]);
        vazio       = (contagem == 4'd0) && (mascara == '0);
        casou       = 1'b0;
        slot        = 3'd0;
        ja_atingido = 1'b0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!vazio && (k < int'(ativos)) &&
                (registro[X_MSB_BASE + SLOT_PASSO*k -: 4] == x) &&
                (registro[Y_MSB_BASE + SLOT_PASSO*k -: 4] == y)) begin
                casou       = 1'b1;
                slot        = 3'(k);
                ja_atingido = mascara[k];
            end
        end
    end

endmodule

// File: rtl/processador_tiro.sv
// Shot processor: scans the target player's fleet RAM for (x,y), writes back
// the updated record on a hit and reports water/hit/repeat/sunk/game-over.
module processador_tiro #(
    parameter int NUM_ENTRADAS = batalha_pkg::NUM_ENTRADAS,
    parameter int TAM_TAB      = batalha_pkg::TAM_TAB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        jogador_alvo,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    output logic [4:0]  read_addr,
    input  logic [63:0] vetor_leitura,
    output logic [4:0]  write_addr,
    output logic [63:0] vetor,
    output logic        wrep1,
    output logic        wrep2,
    output logic        ocupado,
    output logic        done,
    output logic        agua,
    output logic        acerto,
    output logic        repetido,
    output logic        afundou,
    output logic        invalido,
    output logic        fim_jogo,
    output logic [2:0]  tipo_afundado
);
    import batalha_pkg::*;

    localparam logic [3:0] LIMITE     = 4'(TAM_TAB);
    localparam logic [4:0] ULTIMO_IDX = 5'(NUM_ENTRADAS - 1);

    estado_t     estado, prox;
    logic [4:0]  idx;
    logic        alvo;
    logic [3:0]  x_cap, y_cap;

    logic        acc_acerto, acc_repetido, acc_afundou, acc_invalido, acc_nao_vazio;
    logic [2:0]  acc_tipo;
    logic [7:0]  acc_total;

    logic        vazio, casou, ja_atingido;
    logic [2:0]  slot;
    logic [3:0]  cont_lido, cont_novo, cont_gravado;
    logic [63:0] registro_novo;
    logic        acerto_novo, ultimo, fora_faixa;

    comparador_registro u_comparador (
        .registro    (vetor_leitura[LARG_UTIL-1:0]),
        .x           (x_cap),
        .y           (y_cap),
        .vazio       (vazio),
        .casou       (casou),
        .slot        (slot),
        .ja_atingido (ja_atingido)
    );

    // A zero count with a clear hit bit stays at zero instead of wrapping.
    always_comb begin
        cont_lido     = vetor_leitura[CONT_MSB:CONT_LSB];
        cont_novo     = (cont_lido == 4'd0) ? 4'd0 : cont_lido - 4'd1;
        cont_gravado  = vetor[CONT_MSB:CONT_LSB];
        registro_novo = vetor_leitura;
        registro_novo[CONT_MSB:CONT_LSB] = cont_novo;
        registro_novo[MASCARA_BASE + int'(slot)] = 1'b1;
        registro_novo[LARG_REG-1:LARG_UTIL] = '0;
        acerto_novo   = casou && !ja_atingido;
        ultimo        = (idx == ULTIMO_IDX);
        fora_faixa    = (x >= LIMITE) || (y >= LIMITE);
    end

    assign read_addr = idx;
    assign wrep1     = (estado == GRAVA) && !alvo && !reset;
    assign wrep2     = (estado == GRAVA) &&  alvo && !reset;

    always_ff @(posedge clk) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO: if (start) prox = fora_faixa ? FIM : LE;
            LE:     prox = CMP;
            CMP: begin
                if (acerto_novo) prox = GRAVA;
                else if (ultimo) prox = FIM;
                else             prox = LE;
            end
            GRAVA:  prox = ultimo ? FIM : LE;
            FIM:    prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            alvo          <= 1'b0;
            x_cap         <= '0;
            y_cap         <= '0;
            acc_acerto    <= 1'b0;
            acc_repetido  <= 1'b0;
            acc_afundou   <= 1'b0;
            acc_invalido  <= 1'b0;
            acc_nao_vazio <= 1'b0;
            acc_tipo      <= '0;
            acc_total     <= '0;
            write_addr    <= '0;
            vetor         <= '0;
            ocupado       <= 1'b0;
            done          <= 1'b0;
            agua          <= 1'b0;
            acerto        <= 1'b0;
            repetido      <= 1'b0;
            afundou       <= 1'b0;
            invalido      <= 1'b0;
            fim_jogo      <= 1'b0;
            tipo_afundado <= '0;
        end else begin
            done <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        idx           <= '0;
                        alvo          <= jogador_alvo;
                        x_cap         <= x;
                        y_cap         <= y;
                        acc_acerto    <= 1'b0;
                        acc_repetido  <= 1'b0;
                        acc_afundou   <= 1'b0;
                        acc_invalido  <= fora_faixa;
                        acc_nao_vazio <= 1'b0;
                        acc_tipo      <= '0;
                        acc_total     <= '0;
                        ocupado       <= 1'b1;
                        agua          <= 1'b0;
                        acerto        <= 1'b0;
                        repetido      <= 1'b0;
                        afundou       <= 1'b0;
                        invalido      <= 1'b0;
                        fim_jogo      <= 1'b0;
                        tipo_afundado <= '0;
                    end
                end
                CMP: begin
                    if (!vazio) acc_nao_vazio <= 1'b1;
                    if (casou && ja_atingido) acc_repetido <= 1'b1;
                    if (acerto_novo) begin
                        vetor      <= registro_novo;
                        write_addr <= idx;
                    end else begin
                        acc_total <= acc_total + {4'd0, cont_lido};
                        if (!ultimo) idx <= idx + 5'd1;
                    end
                end
                // The hit entry contributes its post-write count to the fleet total.
                GRAVA: begin
                    acc_acerto <= 1'b1;
                    acc_total  <= acc_total + {4'd0, cont_gravado};
                    if (cont_gravado == 4'd0) begin
                        acc_afundou <= 1'b1;
                        acc_tipo    <= vetor[2:0];
                    end
                    if (!ultimo) idx <= idx + 5'd1;
                end
                FIM: begin
                    done          <= 1'b1;
                    ocupado       <= 1'b0;
                    invalido      <= acc_invalido;
                    agua          <= !acc_invalido && !acc_acerto && !acc_repetido;
                    acerto        <= acc_acerto;
                    repetido      <= acc_repetido && !acc_acerto;
                    afundou       <= acc_afundou;
                    tipo_afundado <= acc_tipo;
                    fim_jogo      <= acc_nao_vazio && (acc_total == 8'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
